// File: rtl/xbar_pkg.sv
// Shared crossbar types: buffered beat layout and dest-to-request decode.
// Used by the ingress buffer, the per-master arbiters and the output mux.
package xbar_pkg;

    localparam int unsigned T_DATA_WIDTH = 8;
    localparam int unsigned M_DATA_COUNT = 3;
    localparam int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_DEST_WIDTH-1:0] dest;
        logic                    last;
    } entry_t;

    // Out-of-range dest decodes to all zeros.
    function automatic logic [M_DATA_COUNT-1:0] dest_to_onehot(input logic [T_DEST_WIDTH-1:0] dest);
        logic [M_DATA_COUNT-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < M_DATA_COUNT; i++) begin
            oh[i] = (32'(dest) == i);
        end
        return oh;
    endfunction

endpackage

// File: rtl/xbar_ingress_buffer_if.sv
// Ingress buffer signal bundle: upstream stream, arbiter request/grant, head beat and status.
interface xbar_ingress_buffer_if
    import xbar_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) ();

    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic [T_DEST_WIDTH-1:0] s_dest_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [M_DATA_COUNT-1:0] req_o;
    logic [T_DATA_WIDTH-1:0] data_o;
    logic                    last_o;
    logic                    valid_o;
    logic                    grant_i;
    logic [ADDR_W:0]         level_o;
    logic                    drop_o;

    modport master (
        output s_data_i, s_dest_i, s_last_i, s_valid_i, grant_i,
        input  s_ready_o, req_o, data_o, last_o, valid_o, level_o, drop_o
    );

    modport slave (
        input  s_data_i, s_dest_i, s_last_i, s_valid_i, grant_i,
        output s_ready_o, req_o, data_o, last_o, valid_o, level_o, drop_o
    );

endinterface

// File: rtl/xbar_sync_fifo.sv
// Synchronous FIFO core with wrap-bit pointers and a fall-through head read.
module xbar_sync_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [ADDR_W:0]  level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (ADDR_W+1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/xbar_ingress_buffer.sv
// Per-slave-port ingress stage: buffers beats, decodes head dest into arbiter requests.
// Build option XBAR_STORE_FORWARD_EN holds the head until a whole packet is stored.
module xbar_ingress_buffer
    import xbar_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  rst,
    xbar_ingress_buffer_if.slave bus
);

    entry_t          wr_entry, head;
    logic            full, empty;
    logic            push, in_range, wr_en, pop, valid;
    logic            drop_q;
    logic [ADDR_W:0] level;

    assign push     = bus.s_valid_i && bus.s_ready_o;
    assign in_range = |dest_to_onehot(bus.s_dest_i);
    assign wr_en    = push && in_range;
    assign pop      = valid && bus.grant_i;
    assign wr_entry = '{data: bus.s_data_i, dest: bus.s_dest_i, last: bus.s_last_i};

    xbar_sync_fifo #(
        .WIDTH  ($bits(entry_t)),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_en),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

`ifdef XBAR_STORE_FORWARD_EN
    logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_d;
    logic            release_q, release_d;
    logic            push_last, pop_last;

    assign push_last = wr_en && bus.s_last_i;
    assign pop_last  = pop && head.last;
    // A full buffer with no complete packet would never drain: release it as cut-through.
    assign valid     = !empty && ((pkt_cnt_q != '0) || full || release_q);

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        release_d = release_q;
        if (push_last && !pop_last)      pkt_cnt_d = pkt_cnt_q + (ADDR_W+1)'(1);
        else if (!push_last && pop_last) pkt_cnt_d = pkt_cnt_q - (ADDR_W+1)'(1);
        if (valid && full && (pkt_cnt_q == '0)) release_d = 1'b1;
        if (pop_last) release_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            release_q <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            release_q <= release_d;
        end
    end
`else
    assign valid = !empty;
`endif

    always_ff @(posedge clk) begin
        if (rst) drop_q <= 1'b0;
        else     drop_q <= push && !in_range;
    end

    assign bus.s_ready_o = !full;
    assign bus.valid_o   = valid;
    assign bus.req_o     = valid ? dest_to_onehot(head.dest) : '0;
    assign bus.data_o    = head.data;
    assign bus.last_o    = head.last;
    assign bus.level_o   = level;
    assign bus.drop_o    = drop_q;

endmodule

// File: tb/tb_xbar_ingress_buffer.sv
// Self-checking bench for xbar_ingress_buffer: cycle vector table plus scoreboarded streams.
module tb_xbar_ingress_buffer;
    import xbar_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef XBAR_STORE_FORWARD_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    xbar_ingress_buffer_if #(.DEPTH(DEPTH)) bus ();

    xbar_ingress_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] dest;
        logic       l;
        logic       g;
        logic [2:0] e_level;
        logic       e_valid;
        logic [2:0] e_req;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_drop;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] dest;
        logic       l;
    } beat_t;

    vec_t  vecs[11];
    beat_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dest,
                         input logic l, input logic g);
        bus.s_valid_i = v;
        bus.s_data_i  = d;
        bus.s_dest_i  = dest;
        bus.s_last_i  = l;
        bus.grant_i   = g;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Granting an empty head is a protocol error on the arbiter side.
    always @(negedge clk) begin
        if (!rst && bus.grant_i) check("grant_needs_valid", 32'(bus.valid_o), 32'd1);
    end

    // Streams n beats from an empty buffer, granting from cycle gstart on.
    task automatic run_stream(input int n, input logic [7:0] base, input int gstart,
                              input bit last_all, input bit sf_gate);
        int    sent = 0;
        int    lvl = 0;
        int    cyc = 0;
        bit    rel = 1'b0;
        bit    exp_v, g, pushed;
        beat_t b;
        while ((sent < n || sb_q.size() > 0) && cyc < 200) begin
            exp_v = (lvl > 0) && (!sf_gate || rel);
            g = (cyc >= gstart) && exp_v;
            b = '{d: 8'(base + 8'(sent)), dest: 2'(sent % 3), l: last_all || (sent == n - 1)};
            drive(sent < n, b.d, b.dest, b.l, g);
            @(negedge clk);
            check("stream_level", 32'(bus.level_o), 32'(lvl));
            check("stream_ready", 32'(bus.s_ready_o), 32'(lvl != DEPTH));
            check("stream_valid", 32'(bus.valid_o), 32'(exp_v));
            if (exp_v) begin
                check("stream_data", 32'(bus.data_o), 32'(sb_q[0].d));
                check("stream_last", 32'(bus.last_o), 32'(sb_q[0].l));
                check("stream_req", 32'(bus.req_o), 32'(3'b001 << sb_q[0].dest));
            end
            pushed = (sent < n) && (lvl != DEPTH);
            if (g) begin
                if (sb_q[0].l) rel = 1'b0;
                void'(sb_q.pop_front());
                lvl--;
            end
            if (pushed) begin
                sb_q.push_back(b);
                sent++;
                lvl++;
            end
            if (lvl == DEPTH) rel = 1'b1;
            next_cycle();
            cyc++;
        end
        if (cyc >= 200) check("stream_timeout", 32'(cyc), 32'd0);
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 8'h11, 2, 0, 0, 3'd0, 1'b0, 3'b000, 8'h00, 0, 0};
        vecs[1]  = '{1, 8'h22, 2, 0, 0, 3'd1, !SF, SF ? 3'b000 : 3'b100, 8'h11, 0, 0};
        vecs[2]  = '{1, 8'h33, 2, 1, 0, 3'd2, !SF, SF ? 3'b000 : 3'b100, 8'h11, 0, 0};
        vecs[3]  = '{0, 8'h00, 0, 0, 0, 3'd3, 1'b1, 3'b100, 8'h11, 0, 0};
        vecs[4]  = '{0, 8'h00, 0, 0, 1, 3'd3, 1'b1, 3'b100, 8'h11, 0, 0};
        vecs[5]  = '{0, 8'h00, 0, 0, 1, 3'd2, 1'b1, 3'b100, 8'h22, 0, 0};
        vecs[6]  = '{0, 8'h00, 0, 0, 1, 3'd1, 1'b1, 3'b100, 8'h33, 1, 0};
        vecs[7]  = '{0, 8'h00, 0, 0, 0, 3'd0, 1'b0, 3'b000, 8'h00, 0, 0};
        vecs[8]  = '{1, 8'h44, 3, 1, 0, 3'd0, 1'b0, 3'b000, 8'h00, 0, 0};
        vecs[9]  = '{0, 8'h00, 0, 0, 0, 3'd0, 1'b0, 3'b000, 8'h00, 0, 1};
        vecs[10] = '{0, 8'h00, 0, 0, 0, 3'd0, 1'b0, 3'b000, 8'h00, 0, 0};

        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        @(negedge clk);
        check("reset_ready", 32'(bus.s_ready_o), 32'd1);
        check("reset_valid", 32'(bus.valid_o), 32'd0);
        check("reset_req", 32'(bus.req_o), 32'd0);
        check("reset_level", 32'(bus.level_o), 32'd0);
        check("reset_drop", 32'(bus.drop_o), 32'd0);
        next_cycle();

        // Three-beat packet, drain, then out-of-range dest drop.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].dest, vecs[i].l, vecs[i].g);
            @(negedge clk);
            check($sformatf("vec%0d_level", i), 32'(bus.level_o), 32'(vecs[i].e_level));
            check($sformatf("vec%0d_ready", i), 32'(bus.s_ready_o), 32'(vecs[i].e_level != 3'd4));
            check($sformatf("vec%0d_valid", i), 32'(bus.valid_o), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_req", i), 32'(bus.req_o), 32'(vecs[i].e_req));
            check($sformatf("vec%0d_drop", i), 32'(bus.drop_o), 32'(vecs[i].e_drop));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i), 32'(bus.data_o), 32'(vecs[i].e_data));
                check($sformatf("vec%0d_last", i), 32'(bus.last_o), 32'(vecs[i].e_last));
            end
            next_cycle();
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

        // Fill to full, hold the fifth beat, then push and pop together across the wrap.
        run_stream(10, 8'h50, 5, 1'b1, 1'b0);

`ifdef XBAR_STORE_FORWARD_EN
        drive(1'b1, 8'hB0, 2'd1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 8'hB1, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        check("sf_partial_valid", 32'(bus.valid_o), 32'd0);
        check("sf_partial_req", 32'(bus.req_o), 32'd0);
        next_cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("sf_complete_valid", 32'(bus.valid_o), 32'd1);
        check("sf_complete_data", 32'(bus.data_o), 32'h0B0);
        next_cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        next_cycle();
        @(negedge clk);
        check("sf_second_data", 32'(bus.data_o), 32'h0B1);
        check("sf_second_last", 32'(bus.last_o), 32'd1);
        next_cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("sf_drained", 32'(bus.level_o), 32'd0);
        next_cycle();

        // Packet longer than the buffer: released at full, held open until its last pops.
        run_stream(6, 8'hC0, 4, 1'b0, 1'b1);
`endif

        // Reset with two beats of an open packet buffered.
        drive(1'b1, 8'hE0, 2'd0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 8'hE1, 2'd0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_level", 32'(bus.level_o), 32'd2);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_level", 32'(bus.level_o), 32'd0);
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_req", 32'(bus.req_o), 32'd0);
        check("midrst_ready", 32'(bus.s_ready_o), 32'd1);
        next_cycle();

        run_stream(3, 8'hA0, 1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xbar_ingress_buffer.md
Name: xbar_ingress_buffer

Overview:
- Per-slave-port ingress stage of the streaming crossbar, one instance per slave port, directly upstream of the per-master round-robin arbiters.
- Buffers incoming stream beats in a small FIFO and decodes the head beat's dest into a one-hot request vector over the master ports.
- Presents head data/last to the crossbar mux and pops the head when this port's grant returns.

Parameters:
- T_DATA_WIDTH, 8, data beat width.
- M_DATA_COUNT, 3, number of master ports; width of the request vector.
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), dest field width.
- DEPTH, 4, FIFO entries; power of 2, >=2.
- ADDR_W, $clog2(DEPTH), FIFO pointer index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_data_i  in  T_DATA_WIDTH  upstream data
- s_dest_i  in  T_DEST_WIDTH  upstream destination master index
- s_last_i  in  1  upstream end-of-packet
- s_valid_i  in  1  upstream valid
- s_ready_o  out  1  upstream ready
- req_o  out  M_DATA_COUNT  one-hot request to the arbiters, bit = head dest
- data_o  out  T_DATA_WIDTH  head beat data
- last_o  out  1  head beat last
- valid_o  out  1  head beat available for arbitration
- grant_i  in  1  head beat consumed this cycle (OR of this port's grant bits)
- level_o  out  ADDR_W+1  current FIFO occupancy
- drop_o  out  1  one-cycle pulse: beat discarded, dest out of range

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset clears pointers, count, packet count and drop_o. After reset: s_ready_o=1, valid_o=0, req_o=0, level_o=0, drop_o=0. Memory contents are not reset. Reset mid-packet discards all buffered beats with no partial flush.
- Storage: DEPTH x {data, dest, last} array; wr_ptr/rd_ptr are ADDR_W+1 bits with the wrap bit.
  - full = (level == DEPTH)
  - empty = (level == 0)
- Push: s_valid_i && s_ready_o. s_ready_o = !full, a function of registered state only, so there is no combinational path from grant_i.
- Out-of-range dest (s_dest_i >= M_DATA_COUNT) on push: the beat is accepted but not written, and drop_o pulses on the next cycle. Acceptance still requires s_ready_o.
- Head outputs: fall-through from the entry at rd_ptr, valid in the same cycle the entry is readable. Write-to-valid latency is 1 cycle: a beat pushed at edge N is visible after edge N.
- When valid_o=0: req_o=0. data_o and last_o hold the stale memory value and are don't-care.
- req_o = valid_o ? (1 << head_dest) : 0. At most one bit is ever set.
- Pop: valid_o && grant_i. grant_i while valid_o=0 is ignored and is an assertion error in the bench.
- Simultaneous push and pop: allowed at any level, including full (s_ready_o=0 when full, so no push occurs that cycle) and empty (no pop when empty; the new beat appears the next cycle). Level is unchanged on push+pop.
- Pointer wrap: ADDR_W LSBs index the array; the MSB distinguishes full from empty.
- Arithmetic: level_o = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).

Optional Feature:
- Macro: XBAR_STORE_FORWARD_EN.
- Defined (store-and-forward):
  - pkt_cnt (ADDR_W+1 bits) counts complete packets stored: +1 on a push with last, -1 on a pop with last, net 0 when both occur.
  - valid_o = !empty && (pkt_cnt != 0 || full). The full override is a deadlock-avoidance cut-through release for packets longer than DEPTH.
  - Once the release is taken for a packet, valid_o stays asserted until that packet's last beat pops, tracked by a release flag.
- Undefined (cut-through): valid_o = !empty, and pkt_cnt logic is absent.

Decomposition:
- Shared package xbar_pkg: entry struct/typedef {data, dest, last} and the helper function dest_to_onehot. Shared with the arbiter and the output mux.
- One natural sub-module: xbar_sync_fifo, the pointer/level/memory core with push/pop/full/empty. xbar_ingress_buffer adds dest decode, the drop path and store-forward gating.

Test Plan:
- Reset then idle -> s_ready_o=1, valid_o=0, req_o=3'b000, level_o=0.
- Push 3 beats dest=2 (data 0x11,0x22,0x33, last on the third), grant_i=0 (cut-through build) -> level_o=3, req_o=3'b100, data_o=0x11. Then grant_i=1 for 3 cycles -> data 0x11,0x22,0x33 in order, last_o=1 on 0x33, then valid_o=0.
- Fill to DEPTH=4 with no grant -> s_ready_o=0 and the 5th beat is held. Assert grant_i and s_valid_i together -> one pop and one push per cycle, level_o stays 4 then 3; wrap exercised over 10 beats with no loss or reorder.
- Push dest=3 with M_DATA_COUNT=3 -> beat not stored, level_o unchanged, drop_o high for exactly 1 cycle.
- XBAR_STORE_FORWARD_EN: push a 2-beat packet with last withheld -> valid_o=0. After the last beat is pushed -> valid_o=1 on the next cycle. Push a 6-beat packet -> valid_o=1 at level 4 (release) and stays 1 until its last beat pops.
- Assert rst mid-packet at level 2 -> next cycle level_o=0, valid_o=0, req_o=0. A following fresh packet passes normally.
